// File: rtl/ssrv_mem_arb_if.sv
// ssrv_mem_arb_if -- bundle of the core-side and memory-side handshake signals
// around the shared-memory arbiter.
//   slave  : the arbiter's view (accepts the two core requests and drives the
//            single memory port)
//   master : the surrounding world's view (cores plus memory)
interface ssrv_mem_arb_if;
  // instruction fetch port
  logic        imem_req;
  logic        imem_cmd;
  logic [31:0] imem_addr;
  logic        imem_req_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_resp;

  // data port
  logic        dmem_req;
  logic        dmem_cmd;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_req_ack;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;

  // shared memory port
  logic        mem_req;
  logic        mem_cmd;
  logic [1:0]  mem_width;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_resp;

  modport slave (
    input  imem_req, imem_cmd, imem_addr,
    output imem_req_ack, imem_rdata, imem_resp,
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp,
    output mem_req, mem_cmd, mem_width, mem_addr, mem_wdata,
    input  mem_req_ack, mem_rdata, mem_resp
  );

  modport master (
    output imem_req, imem_cmd, imem_addr,
    input  imem_req_ack, imem_rdata, imem_resp,
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp,
    input  mem_req, mem_cmd, mem_width, mem_addr, mem_wdata,
    output mem_req_ack, mem_rdata, mem_resp
  );
endinterface

// File: rtl/ssrv_mem_arb.sv
// ssrv_mem_arb -- arbitrates the instruction-fetch and data ports of the core
// onto one shared memory port, one transaction at a time.
//
// Flow: IDLE picks a winner and registers it in grant_q, REQ forwards the
// winner's request until the memory acks it (or the core withdraws it), RESP
// waits for the memory response or a timeout and hands it to the winner.
// Every transaction ends with one IDLE cycle before the next arbitration.
//
// Build option:
//   SSRV_ARB_RR_EN defined   -> a simultaneous request goes to the port that
//                               did not win last time (last_grant_q tracks it)
//   SSRV_ARB_RR_EN undefined -> dmem always wins a simultaneous request
//
// A reset in the middle of a transaction drops it without any core response.
module ssrv_mem_arb #(
  parameter int unsigned TIMEOUT_CYC = 255  // 1..255 cycles waited in RESP
) (
  input logic           clk,
  input logic           rst,
  ssrv_mem_arb_if.slave bus
);

  localparam logic       CMD_READ    = 1'b0;
  localparam logic [1:0] WIDTH_WORD  = 2'b10;
  localparam logic [1:0] RESP_IDLE   = 2'b00;
  localparam logic [1:0] RESP_RDY_ER = 2'b10;
  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  state_e      state_q, state_d;
  grant_e      grant_q, grant_d;
  logic [7:0]  cnt_q, cnt_d;

  grant_e      winner;       // arbitration result for the current IDLE cycle
  logic        gnt_req;      // request line of the currently granted port
  logic        timeout;      // RESP has waited the full budget
  logic [1:0]  resp_out;     // response to hand to the granted port in RESP
  logic [31:0] rdata_out;    // data accompanying resp_out

  // imem is read-only with a fixed word width, so its cmd input carries no
  // information for the memory side.
  logic unused_imem_cmd;
  assign unused_imem_cmd = bus.imem_cmd;

`ifdef SSRV_ARB_RR_EN
  grant_e last_grant_q, last_grant_d;

  // Round-robin history: remembers which port won the most recent grant
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GNT_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Pick the winner among the currently asserted core requests
  always_comb begin
    winner = GNT_D;
    if (bus.imem_req && !bus.dmem_req) begin
      winner = GNT_I;
    end else if (!bus.imem_req && bus.dmem_req) begin
      winner = GNT_D;
    end else if (bus.imem_req && bus.dmem_req) begin
`ifdef SSRV_ARB_RR_EN
      winner = (last_grant_q == GNT_I) ? GNT_D : GNT_I;
`else
      winner = GNT_D;
`endif
    end
  end

  assign gnt_req = (grant_q == GNT_D) ? bus.dmem_req : bus.imem_req;
  assign timeout = (cnt_q == TIMEOUT_VAL);

  // Response seen by the granted port: a real memory response wins over the
  // timeout if both happen in the same cycle.
  always_comb begin
    resp_out  = RESP_IDLE;
    rdata_out = 32'h0;
    if (bus.mem_resp != RESP_IDLE) begin
      resp_out  = bus.mem_resp;
      rdata_out = bus.mem_rdata;
    end else if (timeout) begin
      resp_out  = RESP_RDY_ER;
      rdata_out = 32'h0;
    end
  end

  // State, grant and timeout-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_D;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitration, request hand-off and response wait
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
`ifdef SSRV_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.imem_req || bus.dmem_req) begin
          grant_d = winner;
`ifdef SSRV_ARB_RR_EN
          last_grant_d = winner;
`endif
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!gnt_req) begin
          // core withdrew before the memory accepted: nothing outstanding
          state_d = ST_IDLE;
        end else if (bus.mem_req_ack) begin
          state_d = ST_RESP;
          cnt_d   = 8'h0;
        end
      end
      ST_RESP: begin
        if ((bus.mem_resp != RESP_IDLE) || timeout) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output steering: memory port in REQ, response routing in RESP;
  // everything is held at zero/IDLE while reset is asserted.
  always_comb begin
    bus.imem_req_ack = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus.imem_resp    = RESP_IDLE;
    bus.dmem_req_ack = 1'b0;
    bus.dmem_rdata   = 32'h0;
    bus.dmem_resp    = RESP_IDLE;
    bus.mem_req      = 1'b0;
    bus.mem_cmd      = CMD_READ;
    bus.mem_width    = 2'b00;
    bus.mem_addr     = 32'h0;
    bus.mem_wdata    = 32'h0;
    if (!rst) begin
      case (state_q)
        ST_REQ: begin
          bus.mem_req = gnt_req;
          if (grant_q == GNT_D) begin
            bus.mem_cmd      = bus.dmem_cmd;
            bus.mem_width    = bus.dmem_width;
            bus.mem_addr     = bus.dmem_addr;
            bus.mem_wdata    = bus.dmem_wdata;
            bus.dmem_req_ack = bus.mem_req_ack;
          end else begin
            bus.mem_cmd      = CMD_READ;
            bus.mem_width    = WIDTH_WORD;
            bus.mem_addr     = bus.imem_addr;
            bus.mem_wdata    = 32'h0;
            bus.imem_req_ack = bus.mem_req_ack;
          end
        end
        ST_RESP: begin
          if (grant_q == GNT_D) begin
            bus.dmem_resp  = resp_out;
            bus.dmem_rdata = rdata_out;
          end else begin
            bus.imem_resp  = resp_out;
            bus.imem_rdata = rdata_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssrv_mem_arb.sv
// tb_ssrv_mem_arb -- directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a transaction-level
// model of the arbiter.
module tb_ssrv_mem_arb;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ssrv_mem_arb_if bus();

  ssrv_mem_arb #(.TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.imem_req    = 1'b0;
    bus.imem_cmd    = 1'b0;
    bus.imem_addr   = 32'h0;
    bus.dmem_req    = 1'b0;
    bus.dmem_cmd    = 1'b0;
    bus.dmem_width  = 2'b00;
    bus.dmem_addr   = 32'h0;
    bus.dmem_wdata  = 32'h0;
    bus.mem_req_ack = 1'b0;
    bus.mem_rdata   = 32'h0;
    bus.mem_resp    = 2'b00;
  endtask

  // ---------------- transaction-level reference model ----------------
  // One outstanding transaction at most: who owns it (0=I, 1=D), whether the
  // memory has accepted it, and how long it has waited for a response.
  bit m_busy  = 1'b0;
  bit m_acked = 1'b0;
  int m_owner = 1;
  int m_last  = 1;
  int m_wait  = 0;

  function automatic int pick_winner(input bit ireq, input bit dreq, input int last);
    if (ireq && !dreq) return 0;
    if (dreq && !ireq) return 1;
`ifdef SSRV_ARB_RR_EN
    return (last == 0) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  logic        e_iack, e_dack, e_mreq, e_cmd;
  logic [31:0] e_irdata, e_drdata, e_addr, e_wdata;
  logic [1:0]  e_iresp, e_dresp, e_width, r;
  logic [31:0] d;
  bit          oreq;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      e_iack = 0; e_dack = 0; e_mreq = 0; e_cmd = 0;
      e_irdata = 0; e_drdata = 0; e_addr = 0; e_wdata = 0;
      e_iresp = 0; e_dresp = 0; e_width = 0;
      if (!rst && m_busy) begin
        if (!m_acked) begin
          if (m_owner == 1) begin
            e_mreq = bus.dmem_req;   e_cmd = bus.dmem_cmd;  e_width = bus.dmem_width;
            e_addr = bus.dmem_addr;  e_wdata = bus.dmem_wdata;
            e_dack = bus.mem_req_ack;
          end else begin
            e_mreq = bus.imem_req;   e_cmd = 1'b0;          e_width = 2'b10;
            e_addr = bus.imem_addr;  e_wdata = 32'h0;
            e_iack = bus.mem_req_ack;
          end
        end else begin
          r = 2'b00; d = 32'h0;
          if (bus.mem_resp != 2'b00) begin
            r = bus.mem_resp; d = bus.mem_rdata;
          end else if (m_wait == TO) begin
            r = 2'b10;
          end
          if (m_owner == 1) begin e_dresp = r; e_drdata = d; end
          else begin e_iresp = r; e_irdata = d; end
        end
      end
      chk("cyc_imem_port", 128'({bus.imem_req_ack, bus.imem_rdata, bus.imem_resp}),
          128'({e_iack, e_irdata, e_iresp}));
      chk("cyc_dmem_port", 128'({bus.dmem_req_ack, bus.dmem_rdata, bus.dmem_resp}),
          128'({e_dack, e_drdata, e_dresp}));
      chk("cyc_mem_port", 128'({bus.mem_req, bus.mem_cmd, bus.mem_width, bus.mem_addr, bus.mem_wdata}),
          128'({e_mreq, e_cmd, e_width, e_addr, e_wdata}));

      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_acked = 0; m_owner = 1; m_last = 1; m_wait = 0;
      end else if (!m_busy) begin
        if (bus.imem_req || bus.dmem_req) begin
          m_owner = pick_winner(bus.imem_req, bus.dmem_req, m_last);
          m_last  = m_owner;
          m_busy  = 1; m_acked = 0;
        end
      end else if (!m_acked) begin
        oreq = (m_owner == 1) ? bus.dmem_req : bus.imem_req;
        if (!oreq) m_busy = 0;
        else if (bus.mem_req_ack) begin m_acked = 1; m_wait = 0; end
      end else begin
        if (bus.mem_resp != 2'b00 || m_wait == TO) m_busy = 0;
        else m_wait++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int         dcnt, icnt, n;
  logic [3:0] seq_bits, exp_seq;

  initial begin
    idle_inputs();

    // reset: outputs held at zero even with live inputs
    @(negedge clk);
    rst = 1'b1;
    bus.dmem_req = 1; bus.dmem_cmd = 1; bus.dmem_width = 2'b10;
    bus.dmem_addr = 32'h100; bus.dmem_wdata = 32'hDEADBEEF;
    bus.mem_req_ack = 1; bus.mem_resp = 2'b01; bus.mem_rdata = 32'hAAAA5555;
    #2;
    chk("rst_mem_req", 128'(bus.mem_req), 128'(0));
    chk("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
    chk("rst_dmem_req_ack", 128'(bus.dmem_req_ack), 128'(0));
    chk("rst_dmem_resp", 128'(bus.dmem_resp), 128'(0));
    chk("rst_imem_resp", 128'(bus.imem_resp), 128'(0));

    // dmem write 0x100 / 0xDEADBEEF, ack at once, RDY_OK one cycle later
    @(negedge clk); rst = 1'b0; bus.mem_resp = 2'b00;
    #2 chk("A_idle_mem_req", 128'(bus.mem_req), 128'(0));
    @(negedge clk);
    #2;
    chk("A_req_mem_req", 128'(bus.mem_req), 128'(1));
    chk("A_req_mem_cmd", 128'(bus.mem_cmd), 128'(1));
    chk("A_req_mem_addr", 128'(bus.mem_addr), 128'(32'h100));
    chk("A_req_mem_wdata", 128'(bus.mem_wdata), 128'(32'hDEADBEEF));
    chk("A_req_dmem_ack", 128'(bus.dmem_req_ack), 128'(1));
    chk("A_req_imem_ack", 128'(bus.imem_req_ack), 128'(0));
    @(negedge clk);
    bus.dmem_req = 0; bus.mem_req_ack = 0; bus.mem_resp = 2'b01; bus.mem_rdata = 32'h0;
    #2;
    chk("A_resp_dmem_resp", 128'(bus.dmem_resp), 128'(2'b01));
    dcnt = (bus.dmem_resp != 0) ? 1 : 0;
    icnt = (bus.imem_resp != 0) ? 1 : 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); bus.mem_resp = 2'b00;
      #2;
      if (bus.dmem_resp != 0) dcnt++;
      if (bus.imem_resp != 0) icnt++;
    end
    chk("A_dmem_resp_once", 128'(dcnt), 128'(1));
    chk("A_imem_resp_none", 128'(icnt), 128'(0));

    // imem read 0x200 returning 0x13; cmd input ignored, resp outside RESP ignored
    @(negedge clk); idle_inputs();
    bus.imem_req = 1; bus.imem_cmd = 1; bus.imem_addr = 32'h200;
    bus.dmem_wdata = 32'h55AA55AA; bus.mem_resp = 2'b01; bus.mem_rdata = 32'hFFFFFFFF;
    #2 chk("B_idle_imem_resp", 128'(bus.imem_resp), 128'(0));
    @(negedge clk); bus.mem_req_ack = 1; bus.mem_resp = 2'b00;
    #2;
    chk("B_req_mem_width", 128'(bus.mem_width), 128'(2'b10));
    chk("B_req_mem_cmd", 128'(bus.mem_cmd), 128'(0));
    chk("B_req_mem_addr", 128'(bus.mem_addr), 128'(32'h200));
    chk("B_req_mem_wdata", 128'(bus.mem_wdata), 128'(0));
    chk("B_req_imem_ack", 128'(bus.imem_req_ack), 128'(1));
    @(negedge clk);
    bus.imem_req = 0; bus.mem_req_ack = 0; bus.mem_resp = 2'b01; bus.mem_rdata = 32'h13;
    #2;
    chk("B_resp_imem_rdata", 128'(bus.imem_rdata), 128'(32'h13));
    chk("B_resp_imem_resp", 128'(bus.imem_resp), 128'(2'b01));
    chk("B_resp_dmem_rdata", 128'(bus.dmem_rdata), 128'(0));
    @(negedge clk); idle_inputs();

    // timeout: ack, then silence; RDY_ER on the 5th RESP cycle, late resp ignored
    @(negedge clk); bus.dmem_req = 1; bus.dmem_addr = 32'h300;
    @(negedge clk); bus.mem_req_ack = 1;
    @(negedge clk); bus.dmem_req = 0; bus.mem_req_ack = 0; bus.mem_rdata = 32'h12345678;
    for (int k = 0; k <= TO; k++) begin
      #2;
      chk($sformatf("C_resp_k%0d", k), 128'(bus.dmem_resp), 128'((k == TO) ? 2'b10 : 2'b00));
      if (k == TO) chk("C_err_rdata", 128'(bus.dmem_rdata), 128'(0));
      @(negedge clk);
    end
    bus.mem_resp = 2'b01;
    #2 chk("C_late_dmem_resp", 128'(bus.dmem_resp), 128'(0));
    @(negedge clk);
    #2 chk("C_late2_dmem_resp", 128'(bus.dmem_resp), 128'(0));
    @(negedge clk); idle_inputs();

    // reset while in RESP, then a late response and a fresh imem request
    @(negedge clk); bus.dmem_req = 1; bus.dmem_addr = 32'h340;
    @(negedge clk); bus.mem_req_ack = 1;
    @(negedge clk); bus.dmem_req = 0; bus.mem_req_ack = 0;
    @(negedge clk); rst = 1; bus.mem_resp = 2'b01; bus.mem_rdata = 32'hCAFEF00D;
    #2 chk("D_rst_dmem_resp", 128'(bus.dmem_resp), 128'(0));
    @(negedge clk); rst = 0;
    #2;
    chk("D_late_dmem_resp", 128'(bus.dmem_resp), 128'(0));
    chk("D_late_imem_resp", 128'(bus.imem_resp), 128'(0));
    @(negedge clk); bus.mem_resp = 2'b00; bus.imem_req = 1; bus.imem_addr = 32'h400;
    @(negedge clk); bus.mem_req_ack = 1;
    #2;
    chk("D_next_mem_req", 128'(bus.mem_req), 128'(1));
    chk("D_next_mem_addr", 128'(bus.mem_addr), 128'(32'h400));
    @(negedge clk); bus.imem_req = 0; bus.mem_req_ack = 0; bus.mem_resp = 2'b01; bus.mem_rdata = 32'h77;
    #2 chk("D_next_imem_rdata", 128'(bus.imem_rdata), 128'(32'h77));
    @(negedge clk); idle_inputs();

    // both ports requesting continuously from reset: grant order
    @(negedge clk); rst = 1;
    bus.imem_req = 1; bus.dmem_req = 1; bus.imem_addr = 32'h500; bus.dmem_addr = 32'h600;
    bus.mem_req_ack = 1; bus.mem_resp = 2'b01;
    @(negedge clk); rst = 0;
    n = 0; seq_bits = 4'b0000;
    for (int c = 0; c < 13; c++) begin
      #2;
      if (bus.imem_resp != 0) begin if (n < 4) seq_bits[n] = 1'b0; n++; end
      if (bus.dmem_resp != 0) begin if (n < 4) seq_bits[n] = 1'b1; n++; end
      @(negedge clk);
    end
`ifdef SSRV_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b1111;
`endif
    chk("E_resp_count", 128'(n), 128'(4));
    chk("E_grant_seq", 128'(seq_bits), 128'(exp_seq));
    idle_inputs();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      if (!bus.imem_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.imem_req = 1; bus.imem_cmd = 1'($urandom); bus.imem_addr = $urandom;
        end
      end else if (bus.imem_req_ack ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 19) == 0)) begin
        bus.imem_req = 0;
      end
      if (!bus.dmem_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.dmem_req = 1; bus.dmem_cmd = 1'($urandom); bus.dmem_width = 2'($urandom_range(0, 2));
          bus.dmem_addr = $urandom; bus.dmem_wdata = $urandom;
        end
      end else if (bus.dmem_req_ack ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 19) == 0)) begin
        bus.dmem_req = 0;
      end
      bus.mem_req_ack = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       bus.mem_resp = 2'b01;
        1:       bus.mem_resp = 2'b10;
        default: bus.mem_resp = 2'b00;
      endcase
      bus.mem_rdata = $urandom;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
